sa_matmul_os: RTL and testbench
===============================

Name: sa_matmul_os

Overview:
- Parametrised output-stationary systolic matrix multiplier. Computes C[ROWS×COLS] = A[ROWS×K] · B[K×COLS], with K configurable per job.
- Accepts un-skewed A columns and B rows through a valid/ready stream and skews them internally.
- Holds a valid tag with each operand, so input bubbles are tolerated.
- Returns C one row per handshake, then pulses done.
- Sits between the operand buffers and the result writeback in the matrix datapath.

Parameters:
- DATA_W, 8, signed operand width.
- ACC_W, 20, signed accumulator width. Must be ≥ 2*DATA_W.
- ROWS, 3, rows of A and C.
- COLS, 3, columns of B and C.
- K_MAX, 16, maximum inner dimension.
- SAT, 1, accumulator mode: 1 = signed saturate, 0 = two's-complement wrap.
- Derived: K_W = max(1, clog2(K_MAX)); R_W = max(1, clog2(ROWS)).

Ports:
- clk, in, 1, clock. All logic is on the rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, job request. Accepted only in IDLE.
- cfg_k, in, K_W, K-1 for the job (0..K_MAX-1). Latched when start is accepted.
- busy, out, 1, high from start acceptance until done.
- in_valid, in, 1, an operand beat is present.
- in_ready, out, 1, high only in LOAD.
- a_col, in, ROWS*DATA_W, column k of A. Element i is at bits [i*DATA_W +: DATA_W].
- b_row, in, COLS*DATA_W, row k of B. Element j is at bits [j*DATA_W +: DATA_W].
- out_valid, out, 1, result row present.
- out_ready, in, 1, downstream accepts the row.
- out_row, out, COLS*ACC_W, C row out_idx. Element j is at bits [j*ACC_W +: ACC_W].
- out_idx, out, R_W, row index of out_row.
- done, out, 1, one-cycle pulse after the last row handshake.
- sat_flag, out, 1, sticky: some accumulator saturated (SAT=1) or overflowed (SAT=0) during the job.

Behaviour:
- Reset: state=IDLE, all accumulators, skew registers and valid tags cleared. busy, in_ready, out_valid and done are 0. out_row, out_idx and sat_flag are 0. Reset wins over every other input in the same cycle, in any state, including mid-LOAD and mid-OUT.
- FSM: IDLE → LOAD → FLUSH → OUT → IDLE.
- IDLE:
  - On start: latch cfg_k, clear all accumulators and sat_flag, clear the beat counter, set busy, go to LOAD on the next cycle.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1. A beat is accepted on an edge where in_valid & in_ready.
  - Each accepted beat increments the beat counter.
  - When the (cfg_k+1)th beat is accepted, go to FLUSH on that edge. in_ready drops in the following cycle.
  - in_valid=0 cycles insert tag-0 bubbles, which do not accumulate.
- Skew and timing:
  - Element i of a_col passes an i-cycle delay line before PE column 0.
  - Element j of b_row passes a j-cycle delay line before PE row 0.
  - Each PE registers its a operand rightward and its b operand downward, one cycle per hop. The valid tag travels with the data.
  - A beat accepted at edge E is accumulated by PE(i,j) at edge E+1+i+j.
- PE arithmetic:
  - Product is the full 2*DATA_W signed result, sign-extended to ACC_W.
  - SAT=1: the sum clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and any clamp sets sat_flag.
  - SAT=0: the sum wraps, and signed overflow sets sat_flag.
- FLUSH:
  - in_ready=0. A counter runs ROWS+COLS-1 cycles from the last accepted beat.
  - Enter OUT when it expires, so every PE has completed its final accumulation.
- OUT:
  - out_valid=1, with out_idx=r and out_row = accumulators of row r, where r starts at 0.
  - out_row and out_idx hold stable while out_valid & !out_ready.
  - On a handshake, r increments.
  - On the handshake of r=ROWS-1: out_valid=0, done=1 for the next cycle, busy=0, go to IDLE.
- In IDLE the accumulators hold the last job's results. sat_flag holds until the next start.
- start in the same cycle as done is accepted. The new job clears the accumulators.
- cfg_k=0 is a legal K=1 job. cfg_k=K_MAX-1 is the maximum.

Test Plan:
- Identity, K=3 (cfg_k=2): A=I3, B=[[1,2,3],[4,5,6],[7,8,9]], no bubbles → rows out 0,1,2 equal B. done pulses once. in_ready is high for exactly 3 accepted beats.
- Bubbles, K=3: A=[[1,2,3],[4,5,6],[7,8,9]], B=A, with in_valid low on alternate cycles → C=[[30,36,42],[66,81,96],[102,126,150]], identical to the no-bubble run.
- Output backpressure: out_ready low 5 cycles on row 1 → out_row and out_idx=1 stable throughout. Rows arrive in order 0,1,2 with no duplicates.
- Saturation (DATA_W=8, ACC_W=16, SAT=1, K=3): all operands -128 → every C element is 32767 and sat_flag=1. The same run with SAT=0 → every C element is -16384 and sat_flag=1.
- Edge K: cfg_k=0 with a=[2,-3,4], b=[5,6,-7] → C is the outer product, e.g. C[1][2]=21. cfg_k=K_MAX-1 with all ones → every element is K_MAX.
- Control: start pulsed during LOAD is ignored and busy stays high. rst asserted mid-LOAD → next cycle IDLE, all outputs 0. A subsequent start plus a full job produces correct results with no residue from the aborted job.

Source files
------------

// File: rtl/sa_matmul_os.sv
// sa_matmul_os -- output-stationary systolic matrix multiplier.
//
// Computes C[ROWS x COLS] = A[ROWS x K] * B[K x COLS] with K chosen per job.
// Operands arrive un-skewed, one beat per k (column k of A, row k of B), and
// are skewed internally. Every operand carries a valid tag, so input bubbles
// flow through the array without accumulating. When the array has drained,
// C is returned one row per handshake, followed by a one-cycle done pulse.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, cfg_k      job request (taken only in IDLE), K-1 for the job
//   busy              high from start acceptance until the job completes
//   in_valid/in_ready operand beat stream; in_ready is high only in LOAD
//   a_col, b_row      column k of A / row k of B, element i at [i*DATA_W +: DATA_W]
//   out_valid/ready   result row stream
//   out_row, out_idx  C row out_idx, element j at [j*ACC_W +: ACC_W]
//   done              one-cycle pulse after the last row handshake
//   sat_flag          sticky per job: an accumulator saturated / overflowed
//   dbg_state         current FSM state (IDLE=0, LOAD=1, FLUSH=2, OUT=3)
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both high; the source holds its payload stable while
// valid is high and ready is low.

module sa_matmul_os #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int K_MAX  = 16,
    parameter int SAT    = 1,
    localparam int K_W   = (K_MAX > 1) ? $clog2(K_MAX) : 1,
    localparam int R_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [K_W-1:0]           cfg_k,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   a_col,
    input  logic [COLS*DATA_W-1:0]   b_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLS*ACC_W-1:0]    out_row,
    output logic [R_W-1:0]           out_idx,
    output logic                     done,
    output logic                     sat_flag,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // The flush counter covers the skew of the far corner PE: the last beat
    // reaches PE(ROWS-1, COLS-1) ROWS+COLS-1 edges after it is accepted.
    localparam int FL_W = $clog2(ROWS + COLS);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(ROWS + COLS - 2);
    localparam logic [R_W-1:0]  R_LAST  = R_W'(ROWS - 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam int EXT_W = ACC_W + 1 - 2*DATA_W;

    state_t            state_q;
    logic [K_W-1:0]    k_q;
    logic [K_W-1:0]    beat_q;
    logic [FL_W-1:0]   fl_q;
    logic [R_W-1:0]    r_q;
    logic              done_q;
    logic              sat_q;

    logic              start_acc;
    logic              beat_acc;
    logic [ROWS*COLS-1:0] sat_ev;

    assign start_acc = start && (state_q == S_IDLE);
    assign beat_acc  = in_valid && (state_q == S_LOAD);

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            fl_q    <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_acc) begin
                sat_q <= 1'b0;
            end else if (|sat_ev) begin
                sat_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        k_q     <= cfg_k;
                        beat_q  <= '0;
                        r_q     <= '0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (beat_q == k_q) begin
                            fl_q    <= '0;
                            state_q <= S_FLUSH;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (fl_q == FL_LAST) begin
                        state_q <= S_OUT;
                    end else begin
                        fl_q <= fl_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (r_q == R_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign done      = done_q;
    assign out_idx   = r_q;
    assign sat_flag  = sat_q;
    assign dbg_state = state_q;

    // Skewed operand edges of the array and the per-PE forwarded operands.
    logic signed [DATA_W-1:0] a_sk   [ROWS];
    logic                     a_sk_v [ROWS];
    logic signed [DATA_W-1:0] b_sk   [COLS];
    logic                     b_sk_v [COLS];
    logic signed [DATA_W-1:0] a_out   [ROWS][COLS];
    logic                     a_out_v [ROWS][COLS];
    logic signed [DATA_W-1:0] b_out   [ROWS][COLS];
    logic                     b_out_v [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc     [ROWS][COLS];

    // Row i of A is delayed i extra cycles; stage 0 captures the beat and its tag.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew_a
        logic signed [DATA_W-1:0] d_q [0:gi];
        logic                     v_q [0:gi];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d <= gi; d++) begin
                    d_q[d] <= '0;
                    v_q[d] <= 1'b0;
                end
            end else begin
                d_q[0] <= a_col[gi*DATA_W +: DATA_W];
                v_q[0] <= beat_acc;
                for (int d = 1; d <= gi; d++) begin
                    d_q[d] <= d_q[d-1];
                    v_q[d] <= v_q[d-1];
                end
            end
        end
        assign a_sk[gi]   = d_q[gi];
        assign a_sk_v[gi] = v_q[gi];
    end

    // Column j of B is delayed j extra cycles.
    for (genvar gj = 0; gj < COLS; gj++) begin : g_skew_b
        logic signed [DATA_W-1:0] d_q [0:gj];
        logic                     v_q [0:gj];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d <= gj; d++) begin
                    d_q[d] <= '0;
                    v_q[d] <= 1'b0;
                end
            end else begin
                d_q[0] <= b_row[gj*DATA_W +: DATA_W];
                v_q[0] <= beat_acc;
                for (int d = 1; d <= gj; d++) begin
                    d_q[d] <= d_q[d-1];
                    v_q[d] <= v_q[d-1];
                end
            end
        end
        assign b_sk[gj]   = d_q[gj];
        assign b_sk_v[gj] = v_q[gj];
    end

    // Processing elements: accumulate a*b when both operand tags are set,
    // forward a to the right and b downward one cycle later.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
            logic signed [DATA_W-1:0]   a_in;
            logic                       a_in_v;
            logic signed [DATA_W-1:0]   b_in;
            logic                       b_in_v;
            logic signed [2*DATA_W-1:0] prod;
            logic [ACC_W:0]             sum;
            logic                       ovf;
            logic                       fire;
            logic signed [ACC_W-1:0]    res;
            logic signed [DATA_W-1:0]   a_q;
            logic                       a_v_q;
            logic signed [DATA_W-1:0]   b_q;
            logic                       b_v_q;
            logic signed [ACC_W-1:0]    acc_q;

            if (gj == 0) begin : g_a_edge
                assign a_in   = a_sk[gi];
                assign a_in_v = a_sk_v[gi];
            end else begin : g_a_inner
                assign a_in   = a_out[gi][gj-1];
                assign a_in_v = a_out_v[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
                assign b_in   = b_sk[gj];
                assign b_in_v = b_sk_v[gj];
            end else begin : g_b_inner
                assign b_in   = b_out[gi-1][gj];
                assign b_in_v = b_out_v[gi-1][gj];
            end

            assign fire = a_in_v & b_in_v;
            assign prod = a_in * b_in;
            // One guard bit: overflow is visible as disagreement of the top two bits.
            assign sum  = {acc_q[ACC_W-1], acc_q} + {{EXT_W{prod[2*DATA_W-1]}}, prod};
            assign ovf  = sum[ACC_W] ^ sum[ACC_W-1];

            if (SAT != 0) begin : g_sat
                assign res = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
            end else begin : g_wrap
                assign res = sum[ACC_W-1:0];
            end

            assign sat_ev[gi*COLS + gj] = fire & ovf;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    a_v_q <= 1'b0;
                    b_q   <= '0;
                    b_v_q <= 1'b0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_in;
                    a_v_q <= a_in_v;
                    b_q   <= b_in;
                    b_v_q <= b_in_v;
                    if (start_acc) begin
                        acc_q <= '0;
                    end else if (fire) begin
                        acc_q <= res;
                    end
                end
            end

            assign a_out[gi][gj]   = a_q;
            assign a_out_v[gi][gj] = a_v_q;
            assign b_out[gi][gj]   = b_q;
            assign b_out_v[gi][gj] = b_v_q;
            assign acc[gi][gj]     = acc_q;
        end
    end

    // Result row selected by the current row index.
    always_comb begin
        out_row = '0;
        for (int j = 0; j < COLS; j++) begin
            out_row[j*ACC_W +: ACC_W] = acc[r_q][j];
        end
    end

endmodule

// File: tb/tb_sa_matmul_os.sv
module tb_sa_matmul_os;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int ACC_S  = 16;
  localparam int ROWS   = 3;
  localparam int COLS   = 3;
  localparam int K_MAX  = 16;
  localparam int K_W    = 4;
  localparam int R_W    = 2;
  localparam int ROW_W  = COLS * ACC_W;
  localparam int ROW_S  = COLS * ACC_S;
  localparam int NV     = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic                   start = 1'b0;
  logic [K_W-1:0]         cfg_k = '0;
  logic                   in_valid = 1'b0;
  logic [ROWS*DATA_W-1:0] a_col = '0;
  logic [COLS*DATA_W-1:0] b_row = '0;
  logic                   out_ready = 1'b0;

  // main instance (ACC_W=20, saturating)
  logic             busy, in_ready, out_valid, done, sat_flag;
  logic [ROW_W-1:0] out_row;
  logic [R_W-1:0]   out_idx;
  logic [1:0]       dbg_state;

  // 16-bit saturating and wrapping instances
  logic             s_busy, s_in_ready, s_out_valid, s_done, s_sat_flag;
  logic [ROW_S-1:0] s_out_row;
  logic [R_W-1:0]   s_out_idx;
  logic [1:0]       s_dbg_state;
  logic             w_busy, w_in_ready, w_out_valid, w_done, w_sat_flag;
  logic [ROW_S-1:0] w_out_row;
  logic [R_W-1:0]   w_out_idx;
  logic [1:0]       w_dbg_state;

  sa_matmul_os #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS),
                 .K_MAX(K_MAX), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .done(done), .sat_flag(sat_flag), .dbg_state(dbg_state)
  );

  sa_matmul_os #(.DATA_W(DATA_W), .ACC_W(ACC_S), .ROWS(ROWS), .COLS(COLS),
                 .K_MAX(K_MAX), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .busy(s_busy),
    .in_valid(in_valid), .in_ready(s_in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row),
    .out_idx(s_out_idx), .done(s_done), .sat_flag(s_sat_flag), .dbg_state(s_dbg_state)
  );

  sa_matmul_os #(.DATA_W(DATA_W), .ACC_W(ACC_S), .ROWS(ROWS), .COLS(COLS),
                 .K_MAX(K_MAX), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .busy(w_busy),
    .in_valid(in_valid), .in_ready(w_in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_row(w_out_row),
    .out_idx(w_out_idx), .done(w_done), .sat_flag(w_sat_flag), .dbg_state(w_dbg_state)
  );

  // ---------------- vector table ----------------
  typedef struct {
    int k;
    bit bubbles;
    bit stall;
    int a  [K_MAX][ROWS];   // a[k][i] = A[i][k]
    int b  [K_MAX][COLS];   // b[k][j] = B[k][j]
    int c  [ROWS][COLS];    // expected, ACC_W=20 saturating
    int cs [ROWS][COLS];    // expected, ACC_W=16 saturating
    int cw [ROWS][COLS];    // expected, ACC_W=16 wrapping
    bit sat;
    bit sat_s;
    bit sat_w;
  } vec_t;

  vec_t vecs [NV];

  // ---------------- scoreboard ----------------
  logic [ROW_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_job(input int vi, input bit glitch);
    int idx;
    int cyc;
    int waited;
    int not_rdy;
    bit rdy;
    bit vld;
    bit toggle;
    bit glitch_busy;
    logic [ROW_W-1:0] exp_row;
    logic signed [ACC_S-1:0] e16;
    for (int r = 0; r < ROWS; r++) begin
      exp_row = '0;
      for (int j = 0; j < COLS; j++) exp_row[j*ACC_W +: ACC_W] = ACC_W'(vecs[vi].c[r][j]);
      exp_q.push_back(exp_row);
    end
    @(negedge clk);
    start = 1'b1;
    cfg_k = K_W'(vecs[vi].k);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_busy_after_start", vi), busy, 1);
    chk($sformatf("v%0d_in_ready_load", vi), in_ready, 1);
    idx = 0; cyc = 0; not_rdy = 0; toggle = 1'b0; glitch_busy = 1'b1;
    while (idx <= vecs[vi].k && cyc < 200) begin
      rdy = in_ready;
      if (!rdy) not_rdy++;
      vld = !(vecs[vi].bubbles && toggle);
      toggle = !toggle;
      in_valid = vld;
      for (int i = 0; i < ROWS; i++) a_col[i*DATA_W +: DATA_W] = DATA_W'(vecs[vi].a[idx][i]);
      for (int j = 0; j < COLS; j++) b_row[j*DATA_W +: DATA_W] = DATA_W'(vecs[vi].b[idx][j]);
      if (glitch && idx == 1) begin
        start = 1'b1;
        cfg_k = '0;
      end else begin
        start = 1'b0;
        cfg_k = K_W'(vecs[vi].k);
      end
      @(negedge clk);
      if (start) glitch_busy = busy;
      if (vld && rdy) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk($sformatf("v%0d_beats", vi), idx, vecs[vi].k + 1);
    chk($sformatf("v%0d_in_ready_gaps", vi), not_rdy, 0);
    chk($sformatf("v%0d_in_ready_after_last", vi), in_ready, 0);
    if (glitch) chk($sformatf("v%0d_busy_on_glitch_start", vi), glitch_busy, 1);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("v%0d_flush_latency", vi), waited, ROWS + COLS - 1);
    out_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      if (vecs[vi].stall && r == 1) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk($sformatf("v%0d_stall%0d_idx", vi, s), out_idx, 1);
          chk($sformatf("v%0d_stall%0d_row", vi, s), longint'(out_row), longint'(exp_q[0]));
          chk($sformatf("v%0d_stall%0d_valid", vi, s), out_valid, 1);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("v%0d_r%0d_valid", vi, r), out_valid, 1);
      chk($sformatf("v%0d_r%0d_idx", vi, r), out_idx, r);
      chk($sformatf("v%0d_r%0d_done_low", vi, r), done, 0);
      exp_row = exp_q.pop_front();
      chk($sformatf("v%0d_r%0d_row", vi, r), longint'(out_row), longint'(exp_row));
      for (int j = 0; j < COLS; j++) begin
        e16 = s_out_row[j*ACC_S +: ACC_S];
        chk($sformatf("v%0d_sat16_c%0d%0d", vi, r, j), e16, vecs[vi].cs[r][j]);
        e16 = w_out_row[j*ACC_S +: ACC_S];
        chk($sformatf("v%0d_wrap16_c%0d%0d", vi, r, j), e16, vecs[vi].cw[r][j]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk($sformatf("v%0d_done_pulse", vi), done, 1);
    chk($sformatf("v%0d_busy_at_done", vi), busy, 0);
    chk($sformatf("v%0d_out_valid_at_done", vi), out_valid, 0);
    chk($sformatf("v%0d_sat_flag", vi), sat_flag, vecs[vi].sat);
    chk($sformatf("v%0d_sat16_flag", vi), s_sat_flag, vecs[vi].sat_s);
    chk($sformatf("v%0d_wrap16_flag", vi), w_sat_flag, vecs[vi].sat_w);
    @(negedge clk);
    chk($sformatf("v%0d_done_one_cycle", vi), done, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    // fill the vector table
    for (int v = 0; v < NV; v++) begin
      vecs[v].k = 2; vecs[v].bubbles = 1'b0; vecs[v].stall = 1'b0;
      vecs[v].sat = 1'b0; vecs[v].sat_s = 1'b0; vecs[v].sat_w = 1'b0;
      for (int k = 0; k < K_MAX; k++) begin
        for (int i = 0; i < ROWS; i++) vecs[v].a[k][i] = 0;
        for (int j = 0; j < COLS; j++) vecs[v].b[k][j] = 0;
      end
    end
    // 0: identity A, B = 1..9
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) vecs[0].a[k][i] = (i == k) ? 1 : 0;
      for (int j = 0; j < 3; j++) vecs[0].b[k][j] = 3*k + j + 1;
    end
    vecs[0].c = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    // 1: A = B = 1..9 with alternating bubbles; 2: same without bubbles, row-1 stall
    for (int v = 1; v <= 2; v++) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 3; i++) vecs[v].a[k][i] = 3*i + k + 1;
        for (int j = 0; j < 3; j++) vecs[v].b[k][j] = 3*k + j + 1;
      end
      vecs[v].c = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    end
    vecs[1].bubbles = 1'b1;
    vecs[2].stall = 1'b1;
    // 3: K=1 outer product
    vecs[3].k = 0;
    vecs[3].a[0] = '{2, -3, 4};
    vecs[3].b[0] = '{5, 6, -7};
    vecs[3].c = '{'{10, 12, -14}, '{-15, -18, 21}, '{20, 24, -28}};
    // 4: K=K_MAX all ones
    vecs[4].k = K_MAX - 1;
    for (int k = 0; k < K_MAX; k++) begin
      for (int i = 0; i < 3; i++) vecs[4].a[k][i] = 1;
      for (int j = 0; j < 3; j++) vecs[4].b[k][j] = 1;
    end
    vecs[4].c = '{'{16, 16, 16}, '{16, 16, 16}, '{16, 16, 16}};
    // 5: all -128, K=3
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) vecs[5].a[k][i] = -128;
      for (int j = 0; j < 3; j++) vecs[5].b[k][j] = -128;
    end
    vecs[5].c  = '{'{49152, 49152, 49152}, '{49152, 49152, 49152}, '{49152, 49152, 49152}};
    vecs[5].cs = '{'{32767, 32767, 32767}, '{32767, 32767, 32767}, '{32767, 32767, 32767}};
    vecs[5].cw = '{'{-16384, -16384, -16384}, '{-16384, -16384, -16384}, '{-16384, -16384, -16384}};
    vecs[5].sat_s = 1'b1;
    vecs[5].sat_w = 1'b1;
    for (int v = 0; v < 5; v++) begin
      vecs[v].cs = vecs[v].c;
      vecs[v].cw = vecs[v].c;
    end

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out_row", longint'(out_row), 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven jobs
    for (int v = 0; v < NV; v++) run_job(v, 1'b0);

    // start pulsed during LOAD is ignored; also clears the sticky flags
    run_job(0, 1'b1);

    // reset in the middle of LOAD
    @(negedge clk);
    start = 1'b1;
    cfg_k = 4'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < ROWS; i++) a_col[i*DATA_W +: DATA_W] = 8'h80;
    for (int j = 0; j < COLS; j++) b_row[j*DATA_W +: DATA_W] = 8'h80;
    repeat (3) @(negedge clk);
    chk("midload_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_out_row", longint'(out_row), 0);
    chk("midrst_out_idx", out_idx, 0);
    chk("midrst_sat_flag", sat_flag, 0);
    chk("midrst_state", dbg_state, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    run_job(1, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
